tcdm_bank_responder: RTL and testbench

TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

---
 rtl/tcdm_bank_responder.sv | 99 +++++++++
 tb/tb_tcdm_bank_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_responder.sv
// Single-port TCDM bank with byte-enabled writes and a credit-controlled
// response FIFO. Reads are sampled into an in-flight register and buffered in order.
module tcdm_bank_responder #(
  parameter int unsigned NumWords     = 1024,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrMemWidth = $clog2(NumWords),
  parameter int unsigned RespDepth    = 2,
  parameter bit          WriteRespOn  = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddrMemWidth-1:0] addr_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [DataWidth/8-1:0]  be_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DataWidth-1:0]    rdata_o
);

  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW = $clog2(RespDepth + 1);
  localparam int unsigned OccW = CntW + 1;

  logic [DataWidth-1:0] mem_q  [NumWords];
  logic [DataWidth-1:0] fifo_q [RespDepth];
  logic [DataWidth-1:0] infl_data_q;

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            infl_q, infl_d;

  logic            accept, push, pop, credit_ok;
  logic [OccW-1:0] occ;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    if (p == PtrW'(RespDepth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  // Occupancy counts the in-flight beat and credits back a beat leaving this cycle
  assign pop       = (cnt_q != '0) && rready_i;
  assign push      = infl_q;
  assign occ       = {1'b0, cnt_q} + OccW'(infl_q) - OccW'(pop);
  assign credit_ok = occ < OccW'(RespDepth);
  assign gnt_o     = !rst_i && (credit_ok || (!WriteRespOn && wen_i));
  assign accept    = req_i && gnt_o;

  assign rvalid_o  = (cnt_q != '0);
  assign rdata_o   = rvalid_o ? fifo_q[rptr_q] : '0;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    infl_d = accept && (!wen_i || WriteRespOn);
    if (push) wptr_d = next_ptr(wptr_q);
    if (pop)  rptr_d = next_ptr(rptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      infl_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
    end
  end

  // Data storage carries no reset; only touched on an accepted request or a push
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (wen_i) begin
        infl_data_q <= '0;
        for (int b = 0; b < BeW; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        infl_data_q <= mem_q[addr_i];
      end
    end
    if (push) fifo_q[wptr_q] <= infl_data_q;
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: directed scenarios plus random traffic checked
// against a queue-based model of outstanding responses and bank contents.
module tb_tcdm_bank_responder;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int D0 = 2;

  typedef struct {
    logic [31:0] data;
    int          rdy;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst, req, req_w, wen, rready;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, gnt_w, rvalid_w;
  logic [31:0] rdata, rdata_w;

  always #5 clk = ~clk;

  tcdm_bank_responder #(.NumWords(NW), .DataWidth(32), .RespDepth(D0), .WriteRespOn(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata)
  );

  tcdm_bank_responder #(.NumWords(NW), .DataWidth(32), .RespDepth(3), .WriteRespOn(1'b1)) dut_w (
    .clk_i(clk), .rst_i(rst), .req_i(req_w), .gnt_o(gnt_w), .addr_i(addr), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_w), .rready_i(rready), .rdata_o(rdata_w)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          beat_cnt = 0;
  int          wacc = 0;
  logic        acc_last;
  logic [31:0] last_beat;
  resp_t       q[$];
  logic [31:0] mmem[NW];
  logic [31:0] wbeats[$];
  int          bcyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge, update the model, return at posedge+1
  task automatic step();
    logic exp_rv, exp_gnt, beat;
    int occ;
    @(negedge clk);
    cyc++;
    exp_rv = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    if (exp_rv) chk("rdata", rdata, q[0].data);
    beat = exp_rv && rready;
    occ = q.size() - (beat ? 1 : 0);
    exp_gnt = !rst && ((occ < D0) || wen);
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    acc_last = req && exp_gnt;
    if (beat && !rst) begin
      last_beat = q[0].data;
      void'(q.pop_front());
      beat_cnt++;
      bcyc.push_back(cyc);
    end
    if (rst) begin
      q.delete();
    end else if (acc_last) begin
      if (wen) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mmem[addr][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        q.push_back('{data: mmem[addr], rdy: cyc + 2});
      end
    end
    if (rvalid_w && rready) wbeats.push_back(rdata_w);
    if (req_w && gnt_w) wacc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    req = 1'b0;
    req_w = 1'b0;
    rready = 1'b1;
    for (int k = 0; k < max && q.size() > 0; k++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int cur, g, b0;
    rst = 1'b1; req = 1'b0; req_w = 1'b0; wen = 1'b0; rready = 1'b0;
    addr = '0; wdata = '0; be = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd1);
    chk("rst_gnt_w", 32'(gnt_w), 32'd1);

    // Fill the bank with distinct words
    for (int i = 0; i < NW; i++) begin
      req = 1'b1; wen = 1'b1; addr = AW'(i); be = 4'hF;
      wdata = 32'h10203040 + 32'(i) * 32'h01010101;
      step();
    end

    // Full write then read, exact latency
    rready = 1'b1;
    req = 1'b1; wen = 1'b1; addr = 4'd5; wdata = 32'hDEADBEEF; be = 4'hF;
    step();
    wen = 1'b0;
    b0 = beat_cnt;
    step();
    req = 1'b0;
    step();
    chk("lat_early", 32'(beat_cnt - b0), 32'd0);
    step();
    chk("lat_beat", 32'(beat_cnt - b0), 32'd1);
    chk("rd_full", last_beat, 32'hDEADBEEF);

    // Partial byte-enable write
    req = 1'b1; wen = 1'b1; addr = 4'd5; wdata = 32'h11223344; be = 4'b0101;
    step();
    wen = 1'b0;
    step();
    req = 1'b0;
    step();
    step();
    chk("rd_partial", last_beat, 32'hDE22BE44);

    // Back-pressure: only RespDepth reads granted while stalled
    rready = 1'b0; cur = 0;
    for (int k = 0; k < 8; k++) begin
      req = 1'b1; wen = 1'b0; addr = AW'(cur);
      step();
      if (acc_last) cur++;
    end
    chk("stall_grants", 32'(cur), 32'd2);
    rready = 1'b1;
    b0 = beat_cnt;
    for (int k = 0; k < 20 && cur < 4; k++) begin
      addr = AW'(cur);
      step();
      if (acc_last) cur++;
    end
    chk("stall_all_granted", 32'(cur), 32'd4);
    drain(20);
    chk("stall_beats", 32'(beat_cnt - b0), 32'd4);

    // Sustained throughput
    bcyc.delete(); g = 0;
    for (int i = 0; i < 16; i++) begin
      req = 1'b1; wen = 1'b0; addr = AW'(i);
      step();
      if (acc_last) g++;
    end
    chk("b2b_grants", 32'(g), 32'd16);
    drain(20);
    chk("b2b_beats", 32'(bcyc.size()), 32'd16);
    chk("b2b_span", 32'(bcyc.size() == 16 ? bcyc[15] - bcyc[0] : -1), 32'd15);

    // Write responses on/off
    wbeats.delete(); b0 = beat_cnt;
    req = 1'b1; req_w = 1'b1; wen = 1'b1; addr = 4'd7; wdata = 32'hCAFEF00D; be = 4'hF;
    step();
    wen = 1'b0;
    step();
    req = 1'b0; req_w = 1'b0;
    repeat (5) step();
    chk("wresp_beats", 32'(wbeats.size()), 32'd2);
    chk("wresp_first", wbeats.size() > 0 ? wbeats[0] : 32'hFFFF_FFFF, 32'd0);
    chk("wresp_second", wbeats.size() > 1 ? wbeats[1] : 32'hFFFF_FFFF, 32'hCAFEF00D);
    chk("nowresp_beats", 32'(beat_cnt - b0), 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      req = 1'($urandom_range(0, 1));
      wen = ($urandom_range(0, 3) == 0);
      addr = AW'($urandom_range(0, NW - 1));
      wdata = $urandom;
      be = 4'($urandom_range(0, 15));
      rready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(30);

    // Reset with 2 buffered and 1 in flight in the depth-3 instance
    rready = 1'b0; req = 1'b0; wen = 1'b0; req_w = 1'b1; addr = 4'd7; wacc = 0;
    repeat (3) step();
    chk("fill_grants_w", 32'(wacc), 32'd3);
    chk("full_gnt_w", 32'(gnt_w), 32'd0);
    chk("full_rvalid_w", 32'(rvalid_w), 32'd1);
    req_w = 1'b0; rst = 1'b1;
    step();
    chk("inrst_gnt_w", 32'(gnt_w), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rvalid_w", 32'(rvalid_w), 32'd0);
    chk("post_rst_gnt_w", 32'(gnt_w), 32'd1);
    chk("post_rst_rdata_w", rdata_w, 32'd0);
    wbeats.delete();
    rready = 1'b1;
    repeat (5) step();
    chk("no_stale_w", 32'(wbeats.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
